tty_tx: RTL and testbench

TTY_TX -- requirements
Module: tty_tx

---
 rtl/tty_tx_pkg.sv | 25 ++
 rtl/baud_gen.sv | 31 +++
 rtl/tty_tx.sv | 134 +++++++++++++
 tb/tb_tty_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tty_tx_pkg.sv
// Shared CPU parameters: major-state codes, device-04 IOT opcodes, and the
// serial transmitter's own state encoding.
package tty_tx_pkg;

    // CPU major-state codes
    localparam logic [4:0] F1 = 5'd1;
    localparam logic [4:0] F2 = 5'd2;
    localparam logic [4:0] F3 = 5'd3;
    localparam logic [4:0] E0 = 5'd4;

    // Device-04 (teleprinter) IOT opcodes
    localparam logic [11:0] IOT_SPF = 12'o6040;
    localparam logic [11:0] IOT_TSF = 12'o6041;
    localparam logic [11:0] IOT_TCF = 12'o6042;
    localparam logic [11:0] IOT_TPC = 12'o6044;
    localparam logic [11:0] IOT_TLS = 12'o6046;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Restartable bit-period counter: counts 0..DIV-1 and pulses tick for one
// clock on the last count of every period.
module baud_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/tty_tx.sv
// Teleprinter output device: decodes device-04 IOTs in F3, serialises one
// 8-bit character per frame and owns the printer flag.
module tty_tx
    import tty_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 110,
    parameter int STOP_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic [0:11] instruction,
    input  logic [0:11] ac,
    output logic        tx,
    output logic        tskip,
    output logic        tflag,
    output logic        busy
);

    localparam int   DIV       = CLK_FREQ / BAUD;
    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    tx_state_e  st_q, st_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_q, bit_d;
    logic       stop_q, stop_d;
    logic       tx_q, tx_d;
    logic       flag_q, flag_d;
    logic       tick, restart, frame_done;
    logic       unused_ac_hi;

    wire is_f3   = (state == F3);
    wire do_load = is_f3 && (instruction == IOT_TPC || instruction == IOT_TLS);
    wire do_set  = is_f3 && (instruction == IOT_SPF);
    wire do_clr  = is_f3 && (instruction == IOT_TCF || instruction == IOT_TLS);

    assign unused_ac_hi = ^ac[0:3];

    baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= TX_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            flag_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            flag_q  <= flag_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        st_d       = st_q;
        shreg_d    = shreg_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        tx_d       = tx_q;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (st_q)
            TX_IDLE: begin
                if (do_load) begin
                    st_d    = TX_START;
                    shreg_d = ac[4:11];
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                    restart = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    st_d    = TX_DATA;
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        st_d = TX_STOP;
                        tx_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        st_d       = TX_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: st_d = TX_IDLE;
        endcase
    end

    // Frame completion outranks any clear issued on the same clock.
    always_comb begin
        flag_d = flag_q;
        if (frame_done || do_set) begin
            flag_d = 1'b1;
        end else if (do_clr) begin
            flag_d = 1'b0;
        end
    end

    assign tx    = tx_q;
    assign tflag = flag_q;
    assign busy  = (st_q != TX_IDLE);
    assign tskip = (instruction == IOT_TSF) && flag_q;

endmodule

// File: tb/tb_tty_tx.sv
// Self-checking bench for tty_tx: two builds (2 and 1 stop bits) compared
// every cycle against a frame-timing model, plus directed literal checks.
module tb_tty_tx;
    import tty_tx_pkg::*;

    localparam int DIV = 16;

    logic        clk;
    logic        reset;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] ac;
    logic        tx_o[2], tskip_o[2], tflag_o[2], busy_o[2];

    int checks   = 0;
    int failures = 0;

    tty_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) dut_s2 (
        .clk(clk), .reset(reset), .state(state), .instruction(instruction), .ac(ac),
        .tx(tx_o[0]), .tskip(tskip_o[0]), .tflag(tflag_o[0]), .busy(busy_o[0])
    );

    tty_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1)) dut_s1 (
        .clk(clk), .reset(reset), .state(state), .instruction(instruction), .ac(ac),
        .tx(tx_o[1]), .tskip(tskip_o[1]), .tflag(tflag_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is (1 + 8 + stop) bit periods of DIV clocks,
    // counted from the clock edge that accepted the load.
    int         m_stop[2] = '{2, 1};
    logic       m_active[2] = '{1'b0, 1'b0};
    int         m_t[2] = '{0, 0};
    logic       m_flag[2] = '{1'b0, 1'b0};
    logic [7:0] m_chr[2] = '{8'h00, 8'h00};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < 2; m++) begin
                m_active[m] = 1'b0;
                m_t[m]      = 0;
                m_flag[m]   = 1'b0;
                m_chr[m]    = 8'h00;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                logic was_busy, done, f3;
                f3       = (state == F3);
                was_busy = m_active[m];
                done     = 1'b0;
                if (was_busy) begin
                    m_t[m]++;
                    if (m_t[m] == (9 + m_stop[m]) * DIV) begin
                        m_active[m] = 1'b0;
                        done        = 1'b1;
                    end
                end
                if (f3 && !was_busy && (instruction == 12'o6044 || instruction == 12'o6046)) begin
                    m_active[m] = 1'b1;
                    m_t[m]      = 0;
                    m_chr[m]    = ac[4:11];
                end
                if (done || (f3 && instruction == 12'o6040))
                    m_flag[m] = 1'b1;
                else if (f3 && (instruction == 12'o6042 || instruction == 12'o6046))
                    m_flag[m] = 1'b0;
            end
        end
    end

    function automatic logic exp_tx(input int m);
        int idx;
        if (!m_active[m]) return 1'b1;
        idx = m_t[m] / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_chr[m][idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            check($sformatf("model tx%0d", m), {31'd0, tx_o[m]}, {31'd0, exp_tx(m)});
            check($sformatf("model busy%0d", m), {31'd0, busy_o[m]}, {31'd0, m_active[m]});
            check($sformatf("model tflag%0d", m), {31'd0, tflag_o[m]}, {31'd0, m_flag[m]});
            check($sformatf("model tskip%0d", m), {31'd0, tskip_o[m]},
                  {31'd0, (instruction == 12'o6041) && m_flag[m]});
        end
    end

    // Presents one instruction during a single F3 cycle; returns 2 ns after that edge.
    task automatic issue(input logic [11:0] instr, input logic [11:0] acc);
        state       = F3;
        instruction = instr;
        ac          = acc;
        @(posedge clk);
        #2;
        state       = F1;
        instruction = 12'o0000;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] instr_tbl[11];
        instr_tbl = '{12'o6040, 12'o6041, 12'o6042, 12'o6044, 12'o6046,
                      12'o6043, 12'o6045, 12'o6047, 12'o6050, 12'o0000, 12'o6146};
        reset       = 1'b0;
        state       = F1;
        instruction = 12'o0000;
        ac          = 12'o0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", {31'd0, tx_o[0]}, 32'd1);
        check("reset busy", {31'd0, busy_o[0]}, 32'd0);
        check("reset tflag", {31'd0, tflag_o[0]}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        // 0x41 with 6046 on the first F3 after reset; 6046 o0125 mid-frame
        issue(12'o6046, 12'o0101);
        wait_edges(8);
        check("A start bit", {31'd0, tx_o[0]}, 32'd0);
        check("A busy", {31'd0, busy_o[0]}, 32'd1);
        wait_edges(16);
        check("A bit0", {31'd0, tx_o[0]}, 32'd1);
        wait_edges(6);
        issue(12'o6046, 12'o0125);
        wait_edges(9);
        check("A bit1", {31'd0, tx_o[0]}, 32'd0);
        check("A tflag cleared", {31'd0, tflag_o[0]}, 32'd0);
        wait_edges(80);
        check("A bit6", {31'd0, tx_o[0]}, 32'd1);
        wait_edges(16);
        check("A bit7", {31'd0, tx_o[0]}, 32'd0);
        wait_edges(14);
        check("A stop", {31'd0, tx_o[0]}, 32'd1);
        wait_edges(25);
        check("A tflag at 175", {31'd0, tflag_o[0]}, 32'd0);
        check("A busy at 175", {31'd0, busy_o[0]}, 32'd1);
        wait_edges(1);
        check("A tflag at 176", {31'd0, tflag_o[0]}, 32'd1);
        check("A busy at 176", {31'd0, busy_o[0]}, 32'd0);

        // Skip on flag, then clear
        instruction = 12'o6041;
        #1;
        check("tskip set", {31'd0, tskip_o[0]}, 32'd1);
        #1;
        issue(12'o6042, 12'o0000);
        check("TCF clears", {31'd0, tflag_o[0]}, 32'd0);
        instruction = 12'o6041;
        #1;
        check("tskip clear", {31'd0, tskip_o[0]}, 32'd0);
        instruction = 12'o0000;

        // Clear coinciding with frame end: set wins
        issue(12'o6044, 12'($urandom));
        wait_edges(175);
        issue(12'o6042, 12'o0000);
        check("set beats clear", {31'd0, tflag_o[0]}, 32'd1);
        check("idle after end", {31'd0, busy_o[0]}, 32'd0);

        // 6046 on the clock IDLE is re-entered is not loaded
        issue(12'o6046, 12'o0101);
        wait_edges(175);
        issue(12'o6046, 12'o0125);
        check("late TLS ignored busy", {31'd0, busy_o[0]}, 32'd0);
        check("late TLS ignored tx", {31'd0, tx_o[0]}, 32'd1);
        check("late TLS flag", {31'd0, tflag_o[0]}, 32'd1);
        wait_edges(200);

        // Reset mid-frame, then 0xFF
        issue(12'o6044, 12'($urandom));
        wait_edges(68);
        #3 reset = 1'b0;
        #1;
        check("abort tx", {31'd0, tx_o[0]}, 32'd1);
        check("abort busy", {31'd0, busy_o[0]}, 32'd0);
        check("abort tflag", {31'd0, tflag_o[0]}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        issue(12'o6044, 12'o0377);
        wait_edges(8);
        check("FF start", {31'd0, tx_o[0]}, 32'd0);
        wait_edges(16);
        check("FF bit0", {31'd0, tx_o[0]}, 32'd1);
        wait_edges(112);
        check("FF bit7", {31'd0, tx_o[0]}, 32'd1);
        wait_edges(40);
        check("FF tflag", {31'd0, tflag_o[0]}, 32'd1);
        wait_edges(20);

        // One-stop-bit build: 160-clock frame of 0x00
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        issue(12'o6044, 12'o0000);
        wait_edges(140);
        check("S1 bit7", {31'd0, tx_o[1]}, 32'd0);
        wait_edges(10);
        check("S1 stop", {31'd0, tx_o[1]}, 32'd1);
        wait_edges(9);
        check("S1 tflag 159", {31'd0, tflag_o[1]}, 32'd0);
        check("S1 busy 159", {31'd0, busy_o[1]}, 32'd1);
        wait_edges(1);
        check("S1 tflag 160", {31'd0, tflag_o[1]}, 32'd1);
        check("S1 busy 160", {31'd0, busy_o[1]}, 32'd0);
        wait_edges(30);

        // Randomised traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            reset       = ($urandom_range(0, 999) != 0);
            state       = ($urandom_range(0, 3) == 0) ? F3 : 5'($urandom_range(0, 31));
            instruction = instr_tbl[$urandom_range(0, 10)];
            ac          = 12'($urandom);
        end
        @(posedge clk);
        #2;
        reset       = 1'b1;
        state       = F1;
        instruction = 12'o0000;
        wait_edges(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
